// File: rtl/spi_packet_scheduler.sv
// spi_packet_scheduler
//
// Stages quaternion and gyro samples from the sensor controller and publishes
// them as a 128-bit packet for the MCU SPI slave. A packet is published once
// both sources are fresh, or once a single fresh source has waited
// STALE_TIMEOUT cycles. Publishing is only allowed while the synchronized chip
// select has been inactive for CS_GUARD cycles, so the packet never changes
// under an SPI transaction.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   cs_n                  raw MCU chip select (asynchronous, active low)
//   quat_valid, quat_*    one-cycle strobe plus signed quaternion sample
//   gyro_valid, gyro_*    one-cycle strobe plus signed gyro sample
//   initialized, error    sensor controller status, sampled at publish time
//   tx_packet             published packet, byte 0 at [127:120]
//   data_ready            an unread packet is available (MCU interrupt)
//   cs_active             synchronized chip select is low
//   seq_num               sequence number of the last published packet
//   overrun_count         saturating count of packets overwritten unread

module spi_packet_scheduler #(
    parameter int unsigned STALE_TIMEOUT = 2000,
    parameter int unsigned CS_GUARD      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cs_n,
    input  logic         quat_valid,
    input  logic [15:0]  quat_w,
    input  logic [15:0]  quat_x,
    input  logic [15:0]  quat_y,
    input  logic [15:0]  quat_z,
    input  logic         gyro_valid,
    input  logic [15:0]  gyro_x,
    input  logic [15:0]  gyro_y,
    input  logic [15:0]  gyro_z,
    input  logic         initialized,
    input  logic         error,
    output logic [127:0] tx_packet,
    output logic         data_ready,
    output logic         cs_active,
    output logic [3:0]   seq_num,
    output logic [7:0]   overrun_count
);

    localparam int unsigned TmoW   = (STALE_TIMEOUT > 1) ? $clog2(STALE_TIMEOUT) : 1;
    localparam int unsigned GuardW = (CS_GUARD > 0) ? $clog2(CS_GUARD + 1) : 1;

    localparam logic [TmoW-1:0]   TmoLast     = TmoW'(STALE_TIMEOUT - 1);
    localparam logic [GuardW-1:0] GuardMax    = GuardW'(CS_GUARD);
    localparam logic [7:0]        SyncByte    = 8'hAA;
    localparam logic [127:0]      ResetPacket = {SyncByte, 120'd0};

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWaitCs,
        StPublish
    } state_e;

    state_e              state_q, state_d;

    // cs_sync_q[0] is the first synchronizer flop, [1] is sync2, [2] is sync3
    logic [2:0]          cs_sync_q;
    logic                cs_sync2;
    logic                cs_fall;
    logic [GuardW-1:0]   guard_q, guard_d;

    logic [TmoW-1:0]     tmo_q, tmo_d;

    logic [63:0]         quat_q;
    logic [47:0]         gyro_q;
    logic                quat_fresh_q, quat_fresh_d;
    logic                gyro_fresh_q, gyro_fresh_d;

    logic [127:0]        tx_packet_q, tx_packet_d;
    logic                data_ready_q, data_ready_d;
    logic [3:0]          seq_q, seq_d, seq_inc;
    logic [7:0]          overrun_q, overrun_d;

    logic                publish_req;
    logic                cs_ok;
    logic                strobe;
    logic                do_publish;

    // ------------------------------------------------------------------
    // Chip select synchronizer and guard counter
    // ------------------------------------------------------------------
    assign cs_sync2 = cs_sync_q[1];
    // Falling edge of the synchronized CS: the MCU has started a read.
    assign cs_fall  = cs_sync_q[2] & ~cs_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q <= 3'b111;
        end else begin
            cs_sync_q <= {cs_sync_q[1:0], cs_n};
        end
    end

    always_comb begin
        guard_d = guard_q;
        if (!cs_sync2) begin
            guard_d = '0;
        end else if (guard_q != GuardMax) begin
            guard_d = guard_q + 1'b1;
        end
    end

    assign cs_ok = cs_sync2 && (guard_q == GuardMax);

    // ------------------------------------------------------------------
    // Staleness timeout
    // ------------------------------------------------------------------
    // Counts while exactly one source is fresh. It saturates so a publish that
    // is held off by CS cannot wrap it, and clears on publish so a strobe that
    // lands in the publish cycle starts a fresh wait.
    always_comb begin
        tmo_d = tmo_q;
        if (do_publish || (!quat_fresh_q && !gyro_fresh_q)) begin
            tmo_d = '0;
        end else if ((quat_fresh_q ^ gyro_fresh_q) && (tmo_q != TmoLast)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign publish_req = (quat_fresh_q && gyro_fresh_q) || (tmo_q == TmoLast);
    assign strobe      = quat_valid | gyro_valid;

    // ------------------------------------------------------------------
    // Sequencing state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        do_publish = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (strobe) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                // When CS is already quiet the wait state is passed through in
                // the same cycle, so publish follows the request directly.
                if (publish_req) begin
                    state_d = cs_ok ? StPublish : StWaitCs;
                end
            end
            StWaitCs: begin
                if (cs_ok) begin
                    state_d = StPublish;
                end
            end
            StPublish: begin
                do_publish = 1'b1;
                state_d    = strobe ? StCollect : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fresh flags, packet assembly and MCU handshake
    // ------------------------------------------------------------------
    // A strobe in the publish cycle wins over the clear.
    assign quat_fresh_d = quat_valid | (quat_fresh_q & ~do_publish);
    assign gyro_fresh_d = gyro_valid | (gyro_fresh_q & ~do_publish);
    assign seq_inc      = seq_q + 4'd1;

    always_comb begin
        tx_packet_d  = tx_packet_q;
        data_ready_d = data_ready_q;
        seq_d        = seq_q;
        overrun_d    = overrun_q;
        if (cs_fall) begin
            data_ready_d = 1'b0;
        end
        // Publish has priority over the CS clear.
        if (do_publish) begin
            seq_d        = seq_inc;
            tx_packet_d  = {SyncByte, quat_q, gyro_q,
                            seq_inc, error, initialized, gyro_fresh_q, quat_fresh_q};
            data_ready_d = 1'b1;
            if (data_ready_q && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            guard_q      <= '0;
            tmo_q        <= '0;
            quat_fresh_q <= 1'b0;
            gyro_fresh_q <= 1'b0;
            tx_packet_q  <= ResetPacket;
            data_ready_q <= 1'b0;
            seq_q        <= 4'd0;
            overrun_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            guard_q      <= guard_d;
            tmo_q        <= tmo_d;
            quat_fresh_q <= quat_fresh_d;
            gyro_fresh_q <= gyro_fresh_d;
            tx_packet_q  <= tx_packet_d;
            data_ready_q <= data_ready_d;
            seq_q        <= seq_d;
            overrun_q    <= overrun_d;
        end
    end

    // Staging registers: latest sample wins. The packet is assembled from the
    // registered values, so a strobe in the publish cycle goes to the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quat_q <= '0;
            gyro_q <= '0;
        end else begin
            if (quat_valid) begin
                quat_q <= {quat_w, quat_x, quat_y, quat_z};
            end
            if (gyro_valid) begin
                gyro_q <= {gyro_x, gyro_y, gyro_z};
            end
        end
    end

    assign tx_packet     = tx_packet_q;
    assign data_ready    = data_ready_q;
    assign cs_active     = ~cs_sync2;
    assign seq_num       = seq_q;
    assign overrun_count = overrun_q;

endmodule
